// File: rtl/hazard_stall_ctrl.sv
// ----------------------------------------------------------------------------
// hazard_stall_ctrl
//   Hazard and stall controller for the 5-stage pipeline.
//   - Detects load-use hazards combinationally in ID and requests a bubble.
//   - Freezes the back half of the pipeline for MEM_LAT cycles after each
//     accepted data-memory access (two-state FSM: RUN / MEMWAIT).
//   - Keeps a saturating count of cycles in which the PC was held.
//
// Parameters
//   REG_W    register-index width
//   MEM_LAT  freeze cycles per accepted MemReq_i (0 disables the freeze)
//   CNT_W    width of StallCount_o
//
// Ports
//   clk_i           clock, all state on the rising edge
//   rst_i           synchronous reset, active high
//   IFID_Rs_i       rs of the instruction in ID
//   IFID_Rt_i       rt of the instruction in ID
//   IDEX_MemRead_i  instruction in EX is a load
//   IDEX_Rt_i       destination register of the load in EX
//   Branch_i        branch resolved taken in ID
//   MemReq_i        data-memory access issued by MEM this cycle
//   IsHazzard_o     zero ID control signals (bubble into ID/EX)
//   PCWrite_o       PC may update
//   IFIDWrite_o     IF/ID may load
//   IFIDFlush_o     clear IF/ID to NOP
//   PipeStall_o     freeze ID/EX, EX/MEM, MEM/WB
//   StallCount_o    cycles with PCWrite_o == 0 since reset (saturating)
// ----------------------------------------------------------------------------
module hazard_stall_ctrl #(
    parameter int REG_W   = 5,
    parameter int MEM_LAT = 3,
    parameter int CNT_W   = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [REG_W-1:0] IFID_Rs_i,
    input  logic [REG_W-1:0] IFID_Rt_i,
    input  logic             IDEX_MemRead_i,
    input  logic [REG_W-1:0] IDEX_Rt_i,
    input  logic             Branch_i,
    input  logic             MemReq_i,
    output logic             IsHazzard_o,
    output logic             PCWrite_o,
    output logic             IFIDWrite_o,
    output logic             IFIDFlush_o,
    output logic             PipeStall_o,
    output logic [CNT_W-1:0] StallCount_o
);

    // Wait counter must hold MEM_LAT; keep at least one bit when the
    // freeze is disabled so the declarations stay legal.
    localparam int            CW       = (MEM_LAT > 0) ? $clog2(MEM_LAT + 1) : 1;
    localparam logic [CW-1:0] LAT_LOAD = CW'(MEM_LAT);
    localparam logic [CW-1:0] CW_ONE   = CW'(1);
    localparam bit            FREEZE_EN = (MEM_LAT > 0);

    localparam logic [0:0] RUN     = 1'b0;
    localparam logic [0:0] MEMWAIT = 1'b1;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [0:0]       st_reg, st_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic [CNT_W-1:0] stall_cnt_reg;
    logic             load_use;

    // A load into r0 never creates a dependency.
    assign load_use = IDEX_MemRead_i && (IDEX_Rt_i != '0) &&
                      ((IDEX_Rt_i == IFID_Rs_i) || (IDEX_Rt_i == IFID_Rt_i));

    // Next-state logic. MemReq_i is only accepted in RUN, so requests that
    // arrive during a freeze are dropped rather than queued.
    always_comb begin
        st_next  = st_reg;
        cnt_next = cnt_reg;
        case (st_reg)
            RUN: begin
                if (FREEZE_EN && MemReq_i) begin
                    st_next  = MEMWAIT;
                    cnt_next = LAT_LOAD;
                end
            end
            MEMWAIT: begin
                cnt_next = cnt_reg - CW_ONE;
                if (cnt_reg == CW_ONE) begin
                    st_next = RUN;
                end
            end
            default: begin
                st_next  = RUN;
                cnt_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            st_reg  <= RUN;
            cnt_reg <= '0;
        end else begin
            st_reg  <= st_next;
            cnt_reg <= cnt_next;
        end
    end

    // Output decode. Reset is decoded straight from rst_i so the pipeline
    // is held with a bubble during reset regardless of the registered state.
    // Priority: reset > MEMWAIT > load-use > branch.
    always_comb begin
        IsHazzard_o = 1'b0;
        PCWrite_o   = 1'b0;
        IFIDWrite_o = 1'b0;
        IFIDFlush_o = 1'b0;
        PipeStall_o = 1'b0;
        if (rst_i) begin
            IsHazzard_o = 1'b1;
        end else if (st_reg == MEMWAIT) begin
            PipeStall_o = 1'b1;
        end else if (load_use) begin
            // The bubble kills the ID instruction, so a taken branch seen
            // this cycle is ignored; it is re-evaluated after the stall.
            IsHazzard_o = 1'b1;
        end else begin
            PCWrite_o   = 1'b1;
            IFIDWrite_o = 1'b1;
            IFIDFlush_o = Branch_i;
        end
    end

    // Saturating count of PC-hold cycles; reset cycles are not counted.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_reg <= '0;
        end else if (!PCWrite_o && (stall_cnt_reg != CNT_MAX)) begin
            stall_cnt_reg <= stall_cnt_reg + CNT_ONE;
        end
    end

    assign StallCount_o = stall_cnt_reg;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// ----------------------------------------------------------------------------
// tb_hazard_stall_ctrl
//   Scoreboard bench for hazard_stall_ctrl. Two instances share all inputs:
//   dut (CNT_W=16) and dut_sat (CNT_W=4, for counter saturation). Each cycle
//   the stimulus is applied, the expected outputs from a small behavioural
//   model are pushed to a queue, and the queue is popped and compared
//   against the DUT outputs on the falling edge.
// ----------------------------------------------------------------------------
module tb_hazard_stall_ctrl;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [4:0] ifid_rs, ifid_rt, idex_rt;
    logic       idex_mr, branch, mem_req;

    logic        haz_w, pc_w, ifid_w, flush_w, stall_w;
    logic [15:0] cnt_w;
    logic        s_haz_w, s_pc_w, s_ifid_w, s_flush_w, s_stall_w;
    logic [3:0]  s_cnt_w;

    hazard_stall_ctrl #(.REG_W(5), .MEM_LAT(3), .CNT_W(16)) dut (
        .clk_i(clk), .rst_i(rst),
        .IFID_Rs_i(ifid_rs), .IFID_Rt_i(ifid_rt),
        .IDEX_MemRead_i(idex_mr), .IDEX_Rt_i(idex_rt),
        .Branch_i(branch), .MemReq_i(mem_req),
        .IsHazzard_o(haz_w), .PCWrite_o(pc_w), .IFIDWrite_o(ifid_w),
        .IFIDFlush_o(flush_w), .PipeStall_o(stall_w), .StallCount_o(cnt_w)
    );

    hazard_stall_ctrl #(.REG_W(5), .MEM_LAT(3), .CNT_W(4)) dut_sat (
        .clk_i(clk), .rst_i(rst),
        .IFID_Rs_i(ifid_rs), .IFID_Rt_i(ifid_rt),
        .IDEX_MemRead_i(idex_mr), .IDEX_Rt_i(idex_rt),
        .Branch_i(branch), .MemReq_i(mem_req),
        .IsHazzard_o(s_haz_w), .PCWrite_o(s_pc_w), .IFIDWrite_o(s_ifid_w),
        .IFIDFlush_o(s_flush_w), .PipeStall_o(s_stall_w), .StallCount_o(s_cnt_w)
    );

    typedef struct packed {
        logic        haz;
        logic        pc;
        logic        ifid;
        logic        flush;
        logic        stall;
        logic [15:0] cnt;
        logic [4:0]  sflags;
        logic [3:0]  cnt4;
    } out_t;

    typedef struct packed {
        logic       r;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       mr;
        logic [4:0] ert;
        logic       br;
        logic       mreq;
    } stim_t;

    out_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Behavioural model state
    int   m_wait = 0;
    int   m_cnt  = 0;
    int   m_cnt4 = 0;
    logic p_rst, p_pc, p_mreq;

    function automatic stim_t S(input logic r, input int rs, input int rt,
                                input logic mr, input int ert,
                                input logic br, input logic mreq);
        stim_t s;
        s.r = r; s.rs = 5'(rs); s.rt = 5'(rt); s.mr = mr;
        s.ert = 5'(ert); s.br = br; s.mreq = mreq;
        return s;
    endfunction

    function automatic out_t sample();
        out_t o;
        o = {haz_w, pc_w, ifid_w, flush_w, stall_w, cnt_w,
             s_haz_w, s_pc_w, s_ifid_w, s_flush_w, s_stall_w, s_cnt_w};
        return o;
    endfunction

    // Apply one cycle of stimulus, predict outputs, wait for the sample edge.
    task automatic drive(input stim_t s);
        out_t e;
        logic lu;
        rst = s.r; ifid_rs = s.rs; ifid_rt = s.rt; idex_mr = s.mr;
        idex_rt = s.ert; branch = s.br; mem_req = s.mreq;
        lu = s.mr && (s.ert != 5'd0) && ((s.ert == s.rs) || (s.ert == s.rt));
        e = '0;
        if (s.r)             e.haz = 1'b1;
        else if (m_wait > 0) e.stall = 1'b1;
        else if (lu)         e.haz = 1'b1;
        else begin
            e.pc = 1'b1; e.ifid = 1'b1; e.flush = s.br;
        end
        e.cnt    = 16'(m_cnt);
        e.cnt4   = 4'(m_cnt4);
        e.sflags = {e.haz, e.pc, e.ifid, e.flush, e.stall};
        sb.push_back(e);
        p_rst = s.r; p_pc = e.pc; p_mreq = s.mreq;
        @(negedge clk);
    endtask

    // Cross the active edge and update the model state.
    task automatic advance();
        @(posedge clk);
        if (p_rst) begin
            m_wait = 0; m_cnt = 0; m_cnt4 = 0;
        end else begin
            if (!p_pc) begin
                if (m_cnt < 65535) m_cnt++;
                if (m_cnt4 < 15)   m_cnt4++;
            end
            if (m_wait > 0)  m_wait--;
            else if (p_mreq) m_wait = 3;
        end
        #1;
    endtask

    task automatic test_reset();
        stim_t rows[$];
        out_t  o, e;
        // Reset held 3 cycles with hazard and MemReq asserted; then release.
        rows = '{S(1,0,8,1,8,1,1), S(1,0,8,1,8,1,1), S(1,0,8,1,8,1,1),
                 S(0,1,2,0,0,0,0)};
        foreach (rows[i]) begin
            drive(rows[i]);
            o = sample(); e = sb.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL reset[%0d] got=%h want=%h", i, o, e);
            end
            if (i < 3) begin
                n_cmp++;
                if ({o.haz, o.pc, o.stall} !== 3'b100) begin
                    n_bad++;
                    $display("FAIL reset_hold[%0d] got haz/pc/stall=%b want=100", i, {o.haz, o.pc, o.stall});
                end
            end else begin
                n_cmp++;
                if (o.cnt !== 16'd0 || o.pc !== 1'b1) begin
                    n_bad++;
                    $display("FAIL reset_release got cnt=%0d pc=%b want cnt=0 pc=1", o.cnt, o.pc);
                end
            end
            $display("reset[%0d] rst=%b haz=%b pc=%b stall=%b cnt=%0d", i, rows[i].r, o.haz, o.pc, o.stall, o.cnt);
            advance();
        end
    endtask

    task automatic test_load_use();
        stim_t rows[$];
        out_t  o, e;
        rows = '{S(0,3,8,1,8,0,0),   // rt match -> bubble
                 S(0,3,8,0,8,0,0),   // bubble cleared MemRead -> run
                 S(0,8,3,1,8,0,0),   // rs match -> bubble
                 S(0,0,0,1,0,0,0),   // load into r0 -> no hazard
                 S(0,5,6,1,7,0,0)};  // no match -> no hazard
        foreach (rows[i]) begin
            drive(rows[i]);
            o = sample(); e = sb.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL load_use[%0d] got=%h want=%h", i, o, e);
            end
            if (i == 0) begin
                n_cmp++;
                if ({o.haz, o.pc, o.ifid} !== 3'b100) begin
                    n_bad++;
                    $display("FAIL load_use_bubble got haz/pc/ifid=%b want=100", {o.haz, o.pc, o.ifid});
                end
            end
            if (i == 3) begin
                n_cmp++;
                if (o.haz !== 1'b0) begin
                    n_bad++;
                    $display("FAIL load_use_r0 got haz=%b want=0", o.haz);
                end
            end
            $display("load_use[%0d] haz=%b pc=%b ifid=%b", i, o.haz, o.pc, o.ifid);
            advance();
        end
    endtask

    task automatic test_branch();
        stim_t rows[$];
        out_t  o, e;
        logic  want_flush [2] = '{1'b1, 1'b0};
        rows = '{S(0,1,2,0,0,1,0), S(0,1,9,1,9,1,0)};
        foreach (rows[i]) begin
            drive(rows[i]);
            o = sample(); e = sb.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL branch[%0d] got=%h want=%h", i, o, e);
            end
            n_cmp++;
            if (o.flush !== want_flush[i]) begin
                n_bad++;
                $display("FAIL branch_flush[%0d] got=%b want=%b", i, o.flush, want_flush[i]);
            end
            $display("branch[%0d] flush=%b pc=%b haz=%b", i, o.flush, o.pc, o.haz);
            advance();
        end
    endtask

    task automatic test_mem_freeze();
        stim_t rows[$];
        out_t  o, e;
        int    base;
        logic [12:0] want_stall = 13'b0111011101110; // bit 12 = first row
        base = m_cnt;
        rows = '{S(0,1,2,0,0,0,1),   // N   MemReq
                 S(0,1,2,0,0,0,0),   // N+1 freeze
                 S(0,1,2,0,0,0,1),   // N+2 MemReq ignored
                 S(0,1,2,0,0,0,0),   // N+3 freeze
                 S(0,1,2,0,0,0,1),   // N+4 RUN, back-to-back MemReq
                 S(0,1,2,0,0,0,0), S(0,1,2,0,0,0,0), S(0,1,2,0,0,0,0),
                 S(0,0,4,1,4,0,1),   // MemReq together with load-use
                 S(0,1,2,0,0,0,0), S(0,1,2,0,0,0,0), S(0,1,2,0,0,0,0),
                 S(0,1,2,0,0,0,0)};
        foreach (rows[i]) begin
            drive(rows[i]);
            o = sample(); e = sb.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL mem_freeze[%0d] got=%h want=%h", i, o, e);
            end
            n_cmp++;
            if (o.stall !== want_stall[12-i]) begin
                n_bad++;
                $display("FAIL mem_stall[%0d] got=%b want=%b", i, o.stall, want_stall[12-i]);
            end
            if (i == 4 || i == 12) begin
                n_cmp++;
                if (o.cnt !== 16'(base + ((i == 4) ? 3 : 10))) begin
                    n_bad++;
                    $display("FAIL mem_count[%0d] got=%0d want=%0d", i, o.cnt, base + ((i == 4) ? 3 : 10));
                end
            end
            $display("mem_freeze[%0d] req=%b stall=%b pc=%b haz=%b cnt=%0d", i, rows[i].mreq, o.stall, o.pc, o.haz, o.cnt);
            advance();
        end
    endtask

    task automatic test_reset_mid_freeze();
        stim_t rows[$];
        out_t  o, e;
        logic [4:0] want_stall = 5'b01000;
        rows = '{S(0,1,2,0,0,0,1), S(0,1,2,0,0,0,0), S(1,1,2,0,0,0,0),
                 S(0,1,2,0,0,0,0), S(0,1,2,0,0,0,0)};
        foreach (rows[i]) begin
            drive(rows[i]);
            o = sample(); e = sb.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL reset_mid[%0d] got=%h want=%h", i, o, e);
            end
            n_cmp++;
            if (o.stall !== want_stall[4-i]) begin
                n_bad++;
                $display("FAIL reset_mid_stall[%0d] got=%b want=%b", i, o.stall, want_stall[4-i]);
            end
            if (i == 3) begin
                n_cmp++;
                if (o.pc !== 1'b1 || o.cnt !== 16'd0) begin
                    n_bad++;
                    $display("FAIL reset_mid_release got pc=%b cnt=%0d want pc=1 cnt=0", o.pc, o.cnt);
                end
            end
            $display("reset_mid[%0d] rst=%b stall=%b pc=%b", i, rows[i].r, o.stall, o.pc);
            advance();
        end
    endtask

    task automatic test_saturation();
        out_t o, e;
        int   base;
        base = m_cnt;
        for (int i = 0; i < 21; i++) begin
            drive((i < 20) ? S(0,0,8,1,8,0,0) : S(0,1,2,0,0,0,0));
            o = sample(); e = sb.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL saturation[%0d] got=%h want=%h", i, o, e);
            end
            if (i == 20) begin
                n_cmp++;
                if (o.cnt4 !== 4'd15 || o.cnt !== 16'(base + 20)) begin
                    n_bad++;
                    $display("FAIL saturation_end got cnt4=%0d cnt=%0d want cnt4=15 cnt=%0d", o.cnt4, o.cnt, base + 20);
                end
            end
            $display("saturation[%0d] haz=%b cnt=%0d cnt4=%0d", i, o.haz, o.cnt, o.cnt4);
            advance();
        end
    endtask

    initial begin
        rst = 1'b1; ifid_rs = '0; ifid_rt = '0; idex_rt = '0;
        idex_mr = 1'b0; branch = 1'b0; mem_req = 1'b0;
        p_rst = 1'b1; p_pc = 1'b0; p_mreq = 1'b0;
        // One unchecked reset edge so registered state is defined.
        @(posedge clk); #1;
        test_reset();
        test_load_use();
        test_branch();
        test_mem_freeze();
        test_reset_mid_freeze();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
